// File: rtl/fp_add_result_collector.sv
// Result collector for the pipelined FP adder: tracks issues in flight, captures each
// result as it leaves the pipeline, and queues it behind a valid/ready handshake.
module fp_add_result_collector #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4,
    parameter int AW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          flush,
    input  logic          Sz,
    input  logic [7:0]    Ez,
    input  logic [22:0]   Mz_final,
    input  logic          invalid_flag,
    input  logic          overflow_flag,
    input  logic          underflow_flag,
    input  logic          inexact_flag,
    input  logic          zero_flag,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic [4:0]    res_flags,
    output logic [AW:0]   fifo_count,
    output logic [AW:0]   inflight,
    output logic          protocol_err
);

    logic [LATENCY-1:0] tracker_reg;
    logic [LATENCY-1:0] tracker_next;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic [AW:0]        inflight_reg;
    logic               perr_reg;
    logic [36:0]        mem [DEPTH];
    logic [36:0]        head_entry;
    logic [AW+1:0]      credit_sum;
    logic               issue_fire;
    logic               capture;
    logic               pop;

    // Credit uses registered occupancy only, so a same-cycle pop is credited one cycle late.
    assign credit_sum  = {1'b0, count_reg} + {1'b0, inflight_reg};
    assign issue_ready = credit_sum < (AW+2)'(DEPTH);

    assign issue_fire = issue_valid && issue_ready && !flush;
    assign capture    = tracker_reg[LATENCY-1] && !flush;
    assign pop        = res_valid && res_ready && !flush;

    assign tracker_next[0] = issue_fire;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_shift
            assign tracker_next[gi] = tracker_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tracker_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            perr_reg     <= 1'b0;
        end else begin
            if (issue_valid && !issue_ready) begin
                perr_reg <= 1'b1;
            end
            if (flush) begin
                tracker_reg  <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                inflight_reg <= '0;
            end else begin
                tracker_reg <= tracker_next;
                if (capture) begin
                    wr_ptr_reg <= wr_ptr_reg + (AW)'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + (AW)'(1);
                end
                case ({capture, pop})
                    2'b10:   count_reg <= count_reg + (AW+1)'(1);
                    2'b01:   count_reg <= count_reg - (AW+1)'(1);
                    default: count_reg <= count_reg;
                endcase
                case ({issue_fire, capture})
                    2'b10:   inflight_reg <= inflight_reg + (AW+1)'(1);
                    2'b01:   inflight_reg <= inflight_reg - (AW+1)'(1);
                    default: inflight_reg <= inflight_reg;
                endcase
            end
        end
    end

    // Storage is never reset; empty entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr_reg] <= {Sz, Ez, Mz_final, invalid_flag, overflow_flag,
                                underflow_flag, inexact_flag, zero_flag};
        end
    end

    assign head_entry   = mem[rd_ptr_reg];
    assign res_valid    = (count_reg != '0);
    assign res_data     = res_valid ? head_entry[36:5] : 32'h0;
    assign res_flags    = res_valid ? head_entry[4:0]  : 5'h0;
    assign fifo_count   = count_reg;
    assign inflight     = inflight_reg;
    assign protocol_err = perr_reg;

endmodule

// File: tb/tb_fp_add_result_collector.sv
// Directed plus randomized bench for fp_add_result_collector against a queue-based
// model of issue tracking, credit and result ordering.
module tb_fp_add_result_collector;

    localparam int LATENCY = 3;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        flush = 1'b0;
    logic        Sz = 1'b0;
    logic [7:0]  Ez = '0;
    logic [22:0] Mz_final = '0;
    logic        invalid_flag = 1'b0, overflow_flag = 1'b0, underflow_flag = 1'b0;
    logic        inexact_flag = 1'b0, zero_flag = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_flags;
    logic [AW:0] fifo_count;
    logic [AW:0] inflight;
    logic        protocol_err;

    fp_add_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .flush(flush), .Sz(Sz), .Ez(Ez), .Mz_final(Mz_final),
        .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag), .inexact_flag(inexact_flag),
        .zero_flag(zero_flag), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .fifo_count(fifo_count),
        .inflight(inflight), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: issue edge numbers awaiting capture, and queued 37-bit results.
    int          m_pending[$];
    logic [36:0] m_fifo[$];
    bit          m_perr = 1'b0;
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [36:0] head;
        head = (m_fifo.size() != 0) ? m_fifo[0] : 37'h0;
        chk({tag, ".res_valid"}, res_valid, m_fifo.size() != 0);
        chk({tag, ".res_data"}, res_data, head[36:5]);
        chk({tag, ".res_flags"}, res_flags, head[4:0]);
        chk({tag, ".fifo_count"}, fifo_count, m_fifo.size());
        chk({tag, ".inflight"}, inflight, m_pending.size());
        chk({tag, ".issue_ready"}, issue_ready, (m_fifo.size() + m_pending.size()) < DEPTH);
        chk({tag, ".protocol_err"}, protocol_err, m_perr);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input string tag, input logic iv, input logic rr, input logic fl,
                        input logic [36:0] adder);
        bit m_rdy;
        bit cap;
        issue_valid = iv;
        res_ready   = rr;
        flush       = fl;
        {Sz, Ez, Mz_final, invalid_flag, overflow_flag, underflow_flag,
         inexact_flag, zero_flag} = adder;
        m_rdy = (m_fifo.size() + m_pending.size()) < DEPTH;
        cap   = (m_pending.size() != 0) && (edge_n - m_pending[0] == LATENCY);
        @(posedge clk);
        if (iv && !m_rdy) m_perr = 1'b1;
        if (fl) begin
            m_pending.delete();
            m_fifo.delete();
        end else begin
            if (rr && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (cap) begin
                void'(m_pending.pop_front());
                m_fifo.push_back(adder);
            end
            if (iv && m_rdy) m_pending.push_back(edge_n);
        end
        edge_n++;
        #1;
        check_all(tag);
    endtask

    function automatic logic [36:0] rnd_word();
        return {$urandom(), 5'($urandom_range(0, 31))};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fires;
        logic [36:0] zero_res;
        zero_res = {32'h0000_0000, 5'b00001};

        // Reset state
        #2;
        check_all("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        check_all("post_reset");

        // Single issue: 0xF0/0x700000 minus itself gives +0 with zero flag
        step("single_issue", 1'b1, 1'b1, 1'b0, zero_res);
        n = 1;
        while (!res_valid && n < 20) begin
            step("single_wait", 1'b0, 1'b1, 1'b0, zero_res);
            n++;
        end
        chk("single_latency", n, LATENCY + 1);
        chk("single_data", res_data, 32'h0000_0000);
        chk("single_flags", res_flags, 5'b00001);
        step("single_drain", 1'b0, 1'b1, 1'b0, zero_res);
        chk("single_empty", fifo_count, 0);

        // Back-to-back: 1.0+1.0 then 1.0+2.0
        step("b2b_issue0", 1'b1, 1'b1, 1'b0, 37'h0);
        step("b2b_issue1", 1'b1, 1'b1, 1'b0, 37'h0);
        step("b2b_idle", 1'b0, 1'b1, 1'b0, 37'h0);
        step("b2b_cap0", 1'b0, 1'b1, 1'b0, {32'h4000_0000, 5'b0});
        chk("b2b_first", res_data, 32'h4000_0000);
        step("b2b_cap1", 1'b0, 1'b1, 1'b0, {32'h4040_0000, 5'b0});
        chk("b2b_second", res_data, 32'h4040_0000);
        chk("b2b_flags", res_flags, 5'b0);
        step("b2b_drain", 1'b0, 1'b1, 1'b0, 37'h0);

        // Backpressure: only DEPTH issues may fire
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            if (issue_ready) fires++;
            step("bp_fill", 1'b1, 1'b0, 1'b0, rnd_word());
        end
        chk("bp_fires", fires, DEPTH);
        chk("bp_occupancy", fifo_count + inflight, DEPTH);
        chk("bp_ready_low", issue_ready, 1'b0);
        chk("bp_protocol_err", protocol_err, 1'b1);
        step("bp_first_pop", 1'b0, 1'b1, 1'b0, rnd_word());
        chk("bp_ready_back", issue_ready, 1'b1);
        for (int i = 0; i < 3; i++) step("bp_drain", 1'b0, 1'b1, 1'b0, rnd_word());

        // Flush with 1 queued and 2 in flight
        step("fl_issue0", 1'b1, 1'b0, 1'b0, rnd_word());
        step("fl_issue1", 1'b1, 1'b0, 1'b0, rnd_word());
        step("fl_issue2", 1'b1, 1'b0, 1'b0, rnd_word());
        step("fl_cap0", 1'b0, 1'b0, 1'b0, rnd_word());
        chk("fl_pre_count", fifo_count, 1);
        chk("fl_pre_inflight", inflight, 2);
        step("fl_flush", 1'b1, 1'b0, 1'b1, rnd_word());
        chk("fl_count", fifo_count, 0);
        chk("fl_inflight", inflight, 0);
        for (int i = 0; i < LATENCY; i++) step("fl_quiet", 1'b0, 1'b0, 1'b0, rnd_word());
        chk("fl_no_capture", fifo_count, 0);
        chk("fl_perr_kept", protocol_err, 1'b1);

        // Async reset with 3 entries queued
        for (int i = 0; i < 3; i++) step("ar_issue", 1'b1, 1'b0, 1'b0, rnd_word());
        for (int i = 0; i < 3; i++) step("ar_cap", 1'b0, 1'b0, 1'b0, rnd_word());
        chk("ar_pre_count", fifo_count, 3);
        #2 rst = 1'b0;
        #1;
        m_pending.delete();
        m_fifo.delete();
        m_perr = 1'b0;
        check_all("ar_immediate");
        @(posedge clk);
        #1 rst = 1'b1;
        check_all("ar_release");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 39) == 0), rnd_word());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
